// File: rtl/sd_cmd_framer_pkg.sv
// Shared definitions for the SD SPI-mode command framer: FSM encodings,
// frame phases and the CRC7/R1 constants.
package sd_cmd_framer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIG_HI,
    ST_TRIG_LO,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_NEXT,
    ST_POLL_CHK,
    ST_TAIL,
    ST_DONE
  } state_e;

  // Which kind of byte the shared LOAD..WAIT_IDLE byte loop is currently moving.
  typedef enum logic [1:0] {
    PH_FRAME,
    PH_POLL,
    PH_TAIL
  } phase_e;

  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam logic [7:0] FILL_BYTE      = 8'hFF;
  localparam logic [7:0] R1_BIT7_MASK   = 8'h80;
  localparam logic [2:0] LAST_FRAME_IDX = 3'd5;

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Link between the command framer and the SPI byte shifter it drives.
interface sd_cmd_framer_if;
  logic       spi_cs_n_o;
  logic       sttshift_o;
  logic [7:0] ssptdat_o8;
  logic [7:0] sspsreg_i8;
  logic [7:0] sspstat_i8;

  modport master (
    output spi_cs_n_o, sttshift_o, ssptdat_o8,
    input  sspsreg_i8, sspstat_i8
  );

  modport slave (
    input  spi_cs_n_o, sttshift_o, ssptdat_o8,
    output sspsreg_i8, sspstat_i8
  );
endinterface

// File: rtl/sd_cmd_framer_crc7.sv
// Bytewise combinational CRC7 (x^7 + x^3 + 1) update, MSB first.
module sd_crc7
  import sd_cmd_framer_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [6:0] crc_out
);

  logic [6:0] crc_v;
  logic       fb_v;

  always_comb begin
    crc_v = crc_in;
    fb_v  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb_v  = crc_v[6] ^ byte_in[i];
      crc_v = {crc_v[5:0], 1'b0};
      if (fb_v) crc_v = crc_v ^ CRC7_POLY;
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/sd_cmd_framer.sv
// SD SPI-mode command framer: sends the 6-byte command frame, polls for R1,
// then clocks one trailing fill byte before releasing chip select.
module sd_cmd_framer
  import sd_cmd_framer_pkg::*;
#(
  parameter int TRIG_W  = 4,
  parameter int BUSY_TO = 4095,
  parameter int NCR_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_start_i,
  input  logic [5:0]            cmd_idx_i6,
  input  logic [31:0]           cmd_arg_i32,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            resp_o8,
  output logic                  tout_o,
  sd_cmd_framer_if.master       spi
);

  localparam int TW = $clog2(TRIG_W + 1);
  localparam int OW = $clog2(BUSY_TO + 1);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d, crc_next;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [OW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]  resp_q, resp_d;
  logic        tout_q, tout_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  frame_byte;
  logic        shifter_idle;
  logic        unused_stat;

  assign shifter_idle = spi.sspstat_i8[0];
  assign unused_stat  = ^spi.sspstat_i8[7:1];

  always_comb begin
    case (byte_idx_q)
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      default: frame_byte = {crc_q, 1'b1};
    endcase
  end

  sd_crc7 u_crc7 (
    .crc_in  (crc_q),
    .byte_in (frame_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    crc_d      = crc_q;
    byte_idx_d = byte_idx_q;
    poll_cnt_d = poll_cnt_q;
    trig_cnt_d = trig_cnt_q;
    to_cnt_d   = to_cnt_q;
    resp_d     = resp_q;
    tout_d     = tout_q;
    cs_n_d     = cs_n_q;
    dat_d      = dat_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start_i) begin
          idx_d      = cmd_idx_i6;
          arg_d      = cmd_arg_i32;
          cs_n_d     = 1'b0;
          byte_idx_d = 3'd0;
          poll_cnt_d = 4'd0;
          crc_d      = 7'd0;
          phase_d    = PH_FRAME;
          tout_d     = 1'b0;
          resp_d     = FILL_BYTE;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        trig_cnt_d = '0;
        state_d    = ST_TRIG_HI;
        if (phase_q == PH_FRAME) begin
          dat_d = frame_byte;
          // The CRC byte itself is not folded into the running CRC.
          if (byte_idx_q != LAST_FRAME_IDX) crc_d = crc_next;
        end else begin
          dat_d = FILL_BYTE;
        end
      end
      ST_TRIG_HI: begin
        if (trig_cnt_q == TW'(TRIG_W - 1)) state_d = ST_TRIG_LO;
        else                               trig_cnt_d = trig_cnt_q + 1'b1;
      end
      ST_TRIG_LO: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!shifter_idle) begin
          state_d = ST_WAIT_IDLE;
        end else if (to_cnt_q == OW'(BUSY_TO - 1)) begin
          // A hung shifter during the tail byte must not loop back into TAIL.
          tout_d = 1'b1;
          if (phase_q == PH_TAIL) begin
            cs_n_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_TAIL;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (shifter_idle) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        case (phase_q)
          PH_FRAME: begin
            if (byte_idx_q == LAST_FRAME_IDX) phase_d = PH_POLL;
            else                              byte_idx_d = byte_idx_q + 3'd1;
            state_d = ST_LOAD;
          end
          PH_POLL: state_d = ST_POLL_CHK;
          default: begin
            cs_n_d  = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_POLL_CHK: begin
        if (poll_cnt_q != 4'hF) poll_cnt_d = poll_cnt_q + 4'd1;
        if ((spi.sspsreg_i8 & R1_BIT7_MASK) == 8'h00) begin
          resp_d  = spi.sspsreg_i8;
          state_d = ST_TAIL;
        end else if (int'(poll_cnt_q) + 1 >= NCR_MAX) begin
          resp_d  = FILL_BYTE;
          tout_d  = 1'b1;
          state_d = ST_TAIL;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_TAIL: begin
        phase_d = PH_TAIL;
        state_d = ST_LOAD;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_FRAME;
      idx_q      <= '0;
      arg_q      <= '0;
      crc_q      <= '0;
      byte_idx_q <= '0;
      poll_cnt_q <= '0;
      trig_cnt_q <= '0;
      to_cnt_q   <= '0;
      resp_q     <= FILL_BYTE;
      tout_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dat_q      <= FILL_BYTE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of every other flop, independent of statement order.
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      crc_q      <= crc_d;
      byte_idx_q <= byte_idx_d;
      poll_cnt_q <= poll_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      to_cnt_q   <= to_cnt_d;
      resp_q     <= resp_d;
      tout_q     <= tout_d;
      cs_n_q     <= cs_n_d;
      dat_q      <= dat_d;
    end
  end

  // Decoded straight from the state flop: the trigger can only be high in TRIG_HI.
  assign spi.sttshift_o = (state_q == ST_TRIG_HI);
  assign spi.spi_cs_n_o = cs_n_q;
  assign spi.ssptdat_o8 = dat_q;
  assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o         = (state_q == ST_DONE);
  assign resp_o8        = resp_q;
  assign tout_o         = tout_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Directed bench for sd_cmd_framer with a behavioural SPI byte-shifter model.
module tb_sd_cmd_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        busy, done, tout;
  logic [7:0]  resp;

  sd_cmd_framer_if spi_if ();

  sd_cmd_framer dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_start_i (cmd_start),
    .cmd_idx_i6  (cmd_idx),
    .cmd_arg_i32 (cmd_arg),
    .busy_o      (busy),
    .done_o      (done),
    .resp_o8     (resp),
    .tout_o      (tout),
    .spi         (spi_if)
  );

  always #5 clk = ~clk;

  // Shifter model configuration (written only by the stimulus block)
  int         resp_poll = 0;   // 1-based poll that answers; 0 = never
  logic [7:0] resp_val  = 8'hFF;
  logic       hang      = 1'b0;

  // Shifter model state
  logic [7:0] tx_log [32];
  int         frame_cnt;
  int         busy_cnt;
  logic [7:0] pend;
  logic       trig_prev, cs_prev;
  int         fall_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_if.sspstat_i8 <= 8'h01;
      spi_if.sspsreg_i8 <= 8'hFF;
      trig_prev <= 1'b0;
      cs_prev   <= 1'b1;
      frame_cnt <= 0;
      busy_cnt  <= 0;
      pend      <= 8'hFF;
    end else begin
      trig_prev <= spi_if.sttshift_o;
      cs_prev   <= spi_if.spi_cs_n_o;
      if (cs_prev && !spi_if.spi_cs_n_o) begin
        frame_cnt <= 0;
      end else if (trig_prev && !spi_if.sttshift_o) begin
        if (frame_cnt < 32) tx_log[frame_cnt] <= spi_if.ssptdat_o8;
        frame_cnt <= frame_cnt + 1;
        pend <= (resp_poll != 0 && frame_cnt == 5 + resp_poll) ? resp_val : 8'hFF;
        if (!hang) begin
          spi_if.sspstat_i8 <= 8'h00;
          busy_cnt <= 3;
        end
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          spi_if.sspstat_i8 <= 8'h01;
          spi_if.sspsreg_i8 <= pend;
        end
      end
    end
  end

  always @(negedge spi_if.sttshift_o) fall_cnt++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clk);
    cmd_idx   = idx;
    cmd_arg   = arg;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  logic [7:0] exp_cmd0 [9]  = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] exp_cmd8 [8]  = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'hFF, 8'hFF};

  initial begin
    int   cyc;
    logic seen;
    int   falls_before;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tout", tout, 1'b0);
    check("rst_resp", resp, 8'hFF);
    check("rst_cs_n", spi_if.spi_cs_n_o, 1'b1);
    check("rst_trig", spi_if.sttshift_o, 1'b0);
    check("rst_dat",  spi_if.ssptdat_o8, 8'hFF);
    rst_n = 1'b1;

    // CMD0, R1 on poll 2, with an ignored second start mid-frame
    resp_poll = 2; resp_val = 8'h01; hang = 1'b0;
    start_cmd(6'd0, 32'h0000_0000);
    check("cmd0_busy", busy, 1'b1);
    check("cmd0_cs_low", spi_if.spi_cs_n_o, 1'b0);
    repeat (20) @(negedge clk);
    start_cmd(6'd17, 32'hFFFF_FFFF);
    wait_done(2000, cyc, seen);
    check("cmd0_done_seen", seen, 1'b1);
    check("cmd0_busy_at_done", busy, 1'b0);
    check("cmd0_resp", resp, 8'h01);
    check("cmd0_tout", tout, 1'b0);
    check("cmd0_cs_high", spi_if.spi_cs_n_o, 1'b1);
    check("cmd0_nbytes", frame_cnt, 9);
    for (int i = 0; i < 9; i++) check($sformatf("cmd0_byte%0d", i), tx_log[i], exp_cmd0[i]);
    @(negedge clk);
    check("cmd0_done_width", done, 1'b0);

    // CMD8, R1 on poll 1
    repeat (5) @(negedge clk);
    check("resp_held", resp, 8'h01);
    resp_poll = 1; resp_val = 8'h01;
    start_cmd(6'd8, 32'h0000_01AA);
    wait_done(2000, cyc, seen);
    check("cmd8_done_seen", seen, 1'b1);
    check("cmd8_resp", resp, 8'h01);
    check("cmd8_tout", tout, 1'b0);
    check("cmd8_cs_high", spi_if.spi_cs_n_o, 1'b1);
    check("cmd8_nbytes", frame_cnt, 8);
    for (int i = 0; i < 8; i++) check($sformatf("cmd8_byte%0d", i), tx_log[i], exp_cmd8[i]);

    // No response: exactly NCR_MAX polls then a tail byte
    resp_poll = 0;
    start_cmd(6'd0, 32'h0000_0000);
    wait_done(3000, cyc, seen);
    check("ncr_done_seen", seen, 1'b1);
    check("ncr_resp", resp, 8'hFF);
    check("ncr_tout", tout, 1'b1);
    check("ncr_cs_high", spi_if.spi_cs_n_o, 1'b1);
    check("ncr_nbytes", frame_cnt, 15);
    check("ncr_crc_byte", tx_log[5], 8'h95);
    check("ncr_last_byte", tx_log[14], 8'hFF);

    // Shifter never goes busy: timeout on the first byte, then on the tail
    hang = 1'b1;
    start_cmd(6'd0, 32'h0000_0000);
    check("hang_tout_cleared", tout, 1'b0);
    wait_done(10000, cyc, seen);
    check("hang_done_seen", seen, 1'b1);
    check("hang_tout", tout, 1'b1);
    check("hang_cs_high", spi_if.spi_cs_n_o, 1'b1);
    check("hang_busy", busy, 1'b0);
    check("hang_latency_ge_2x_busy_to", (cyc >= 8190) ? 1'b1 : 1'b0, 1'b1);
    check("hang_nbytes", frame_cnt, 2);
    check("hang_byte0", tx_log[0], 8'h40);
    check("hang_tail", tx_log[1], 8'hFF);

    // Reset while byte 3 is in flight
    hang = 1'b0; resp_poll = 1;
    start_cmd(6'd17, 32'h1234_5678);
    cyc = 0;
    while (frame_cnt != 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_byte3_reached", frame_cnt, 4);
    falls_before = fall_cnt;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_tout", tout, 1'b0);
    check("mrst_resp", resp, 8'hFF);
    check("mrst_cs_n", spi_if.spi_cs_n_o, 1'b1);
    check("mrst_trig", spi_if.sttshift_o, 1'b0);
    check("mrst_dat",  spi_if.ssptdat_o8, 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mrst_no_trig_fall", fall_cnt, falls_before);
    check("mrst_idle_busy", busy, 1'b0);
    check("mrst_idle_cs", spi_if.spi_cs_n_o, 1'b1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_framer.md
SD_CMD_FRAMER -- requirements
Module: sd_cmd_framer

Interface
REQ-001 SHALL have parameter TRIG_W, default 4, the number of clk_i cycles sttshift_o is held high per byte.
REQ-002 SHALL have parameter BUSY_TO, default 4095, the clk_i-cycle limit for the shifter to report busy after a trigger.
REQ-003 SHALL have parameter NCR_MAX, default 8, the maximum number of response poll bytes.
REQ-004 clk_i  input  1  single system clock; every flop is clocked by clk_i.
REQ-005 rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 cmd_start_i  input  1  one-cycle request to issue a command.
REQ-007 cmd_idx_i6  input  6  SD command index.
REQ-008 cmd_arg_i32  input  32  command argument.
REQ-009 busy_o  output  1  high from accepted start until done_o.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 resp_o8  output  8  R1 response byte, held until the next start.
REQ-012 tout_o  output  1  error flag (no response, or shifter hang), valid with done_o.
REQ-013 spi_cs_n_o  output  1  SD chip select, active low.
REQ-014 sttshift_o  output  1  byte trigger to the SPI byte shifter; the shifter acts on its falling edge.
REQ-015 ssptdat_o8  output  8  byte to transmit, stable from LOAD until the byte completes.
REQ-016 sspsreg_i8  input  8  byte received by the shifter.
REQ-017 sspstat_i8  input  8  shifter status; bit0 is idle.

Function
REQ-018 SHALL use these states: IDLE, LOAD, TRIG_HI, TRIG_LO, WAIT_BUSY, WAIT_IDLE, NEXT, POLL_CHK, TAIL, DONE.
REQ-019 SHALL accept cmd_start_i only in IDLE; a start asserted while busy SHALL be ignored.
REQ-020 On accept, SHALL latch idx/arg, drive spi_cs_n_o low, and clear the byte index to 0.
REQ-021 Frame byte order SHALL be: {2'b01, idx}, then arg[31:24], arg[23:16], arg[15:8], arg[7:0], then {crc7, 1'b1}.
REQ-022 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed over the first 40 frame bits, MSB first.
REQ-023 Per byte, the sequence SHALL be:
- LOAD: drive ssptdat_o8.
- TRIG_HI: sttshift_o=1 for TRIG_W cycles.
- TRIG_LO: sttshift_o=0.
- WAIT_BUSY: wait until idle=0.
- WAIT_IDLE: wait until idle=1.
REQ-024 If idle=0 is not seen within BUSY_TO cycles in WAIT_BUSY, SHALL set tout_o, skip to TAIL, and not retry.
REQ-025 After the 6th frame byte, SHALL transmit 0xFF poll bytes; after each, POLL_CHK samples sspsreg_i8.
REQ-026 In POLL_CHK, a sample with bit7=0 SHALL be captured into resp_o8 and the block SHALL go to TAIL.
REQ-027 After NCR_MAX polls with bit7=1, SHALL set resp_o8=0xFF and tout_o=1.
REQ-028 TAIL SHALL send one 0xFF byte with CS still low, then drive spi_cs_n_o high.
REQ-029 DONE SHALL pulse done_o for 1 cycle, drop busy_o in the same cycle, and return to IDLE.
REQ-030 The poll counter SHALL be 4-bit and saturating; the byte index SHALL be 3-bit (0..5).
REQ-031 sttshift_o SHALL never toggle outside TRIG_HI/TRIG_LO.

Reset
REQ-032 On reset: state=IDLE, busy_o=0, done_o=0, tout_o=0, resp_o8=0xFF, spi_cs_n_o=1, sttshift_o=0, ssptdat_o8=0xFF, all counters 0.
REQ-033 Reset mid-frame SHALL abort immediately with no further trigger edge; the shifter is reset by the same source.

Structure
REQ-034 A shared package SHALL hold the state encodings, the CRC7 polynomial constant 7'h09, the 0xFF fill byte and the R1 bit7 mask.
REQ-035 Sub-module sd_crc7 SHALL be a bytewise combinational CRC7 update (crc_in, byte_in -> crc_out), iterated once per frame byte in LOAD.

Verification
REQ-036 CMD0, arg 0x00000000 -> transmitted bytes 40 00 00 00 00 95 FF; shifter model returns R1=0x01 on poll 2 -> resp_o8=0x01, tout_o=0, then one trailing FF.
REQ-037 CMD8, arg 0x000001AA -> transmitted bytes 48 00 00 01 AA 87; R1=0x01 on poll 1 -> done_o pulse, spi_cs_n_o high after the tail byte.
REQ-038 Model always returns 0xFF -> exactly 8 polls, resp_o8=0xFF, tout_o=1, CS released.
REQ-039 Model never drops idle after a trigger -> tout_o=1 after 4095 cycles, done_o pulses, CS high.
REQ-040 Second cmd_start_i during a frame -> ignored, frame bytes unchanged; assert rst_n_i mid-byte-3 -> all outputs at reset values, no sttshift_o falling edge.
